// File: rtl/perip_pkg.sv
// Shared encodings for the peripheral load/store adapter: access sizes,
// FSM state enum and the legality check applied at request acceptance.
package perip_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CAP,
    RSP
  } state_e;

  // Illegal size or an address not aligned to the access width.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == SZ_X) ||
           ((size == SZ_H) && addr_lo[0]) ||
           ((size == SZ_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/perip_lane_align.sv
// Combinational byte-lane logic: store mask, store data replication and
// load lane extraction with sign/zero extension.
module perip_lane_align
  import perip_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  mask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    mask_o  = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SZ_B: begin
        mask_o  = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      end
      SZ_H: begin
        mask_o  = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      end
      SZ_W: begin
        mask_o  = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: begin
        mask_o  = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/perip_lsu_adapter.sv
// Bridges a valid/ready core load/store port onto a simple peripheral bus:
// one write strobe per store, one-cycle-latency reads, registered response.
module perip_lsu_adapter
  import perip_pkg::*;
#(
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] perip_waddr_o,
  output logic [31:0] perip_wdata_o,
  output logic        perip_wen_o,
  output logic [3:0]  perip_mask_o,
  output logic [31:0] perip_raddr_o,
  input  logic [31:0] perip_rdata_i
);

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        unsigned_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        req_bad;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  assign accept  = req_valid_i && (state_q == IDLE);
  assign req_bad = is_bad_access(req_size_i, req_addr_i[1:0]);

  perip_lane_align u_lane_align (
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .unsigned_i (unsigned_q),
    .wdata_i    (wdata_q),
    .rdata_i    (perip_rdata_i),
    .mask_o     (lane_mask),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata)
  );

  // The response register is only written at acceptance and in CAP, so it
  // holds steady for as long as the core stalls in RSP.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rdata_d = req_bad ? ERR_RDATA : 32'h0;
          err_d   = req_bad;
          if (req_bad)       state_d = RSP;
          else if (req_we_i) state_d = WR;
          else               state_d = RD;
        end
      end
      WR:  state_d = RSP;
      RD:  state_d = CAP;
      CAP: begin
        rdata_d = lane_rdata;
        state_d = RSP;
      end
      RSP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      size_q     <= 2'b00;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q     <= req_addr_i;
        wdata_q    <= req_wdata_i;
        size_q     <= req_size_i;
        we_q       <= req_we_i;
        unsigned_q <= req_unsigned_i;
      end
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RSP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign perip_waddr_o = {addr_q[31:2], 2'b00};
  assign perip_raddr_o = {addr_q[31:2], 2'b00};
  assign perip_wdata_o = lane_wdata;
  assign perip_wen_o   = (state_q == WR) && we_q;
  assign perip_mask_o  = (state_q == WR) ? lane_mask : 4'b0000;

endmodule

// File: tb/tb_perip_lsu_adapter.sv
// Self-checking bench for perip_lsu_adapter: directed scenarios followed by
// random transactions checked against an arithmetic reference model.
module tb_perip_lsu_adapter;

  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic [1:0]  req_size_i = 2'd0;
  logic        req_unsigned_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] perip_waddr_o;
  logic [31:0] perip_wdata_o;
  logic        perip_wen_o;
  logic [3:0]  perip_mask_o;
  logic [31:0] perip_raddr_o;
  logic [31:0] perip_rdata_i = 32'h0;

  int compared   = 0;
  int mismatched = 0;

  perip_lsu_adapter #(.ERR_RDATA(ERR)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .perip_waddr_o  (perip_waddr_o),
    .perip_wdata_o  (perip_wdata_o),
    .perip_wen_o    (perip_wen_o),
    .perip_mask_o   (perip_mask_o),
    .perip_raddr_o  (perip_raddr_o),
    .perip_rdata_i  (perip_rdata_i)
  );

  always #5 clk = ~clk;

  // Reference model: plain arithmetic on the access rules.
  function automatic logic refErr(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
           (size == 2'd2 && (addr % 4) != 0);
  endfunction

  function automatic logic [31:0] refLoad(input logic [1:0] size, input logic [1:0] off,
                                          input logic uns, input logic [31:0] d);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (d >> (8 * int'(off))) & 32'h0000_00FF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (d >> (16 * int'(off[1]))) & 32'h0000_FFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic logic [3:0] refMask(input logic [1:0] size, input logic [1:0] off);
    if (size == 2'd0) return 4'b0001 << off;
    if (size == 2'd1) return 4'b0011 << (2 * int'(off[1]));
    return 4'b1111;
  endfunction

  function automatic logic [31:0] refWdata(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'd0) return {24'h0, w[7:0]} * 32'h0101_0101;
    if (size == 2'd1) return {16'h0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Runs one complete transaction, checking every cycle from acceptance
  // through the response handshake.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic uns, input logic [31:0] capData,
                               input int stall, input logic holdValid);
    logic        isErr;
    logic        inWr;
    int          lat;
    logic [31:0] expR;
    isErr = refErr(size, addr);
    lat   = isErr ? 1 : (we ? 2 : 3);
    expR  = isErr ? ERR : (we ? 32'h0 : refLoad(size, addr[1:0], uns, capData));

    checkOutput("idle_ready", {31'h0, req_ready_o}, 32'h1);
    req_valid_i = 1'b1;
    req_we_i = we;
    req_addr_i = addr;
    req_wdata_i = wdata;
    req_size_i = size;
    req_unsigned_i = uns;
    rsp_ready_i = 1'b0;
    tick();
    req_valid_i = holdValid;
    req_we_i = 1'($urandom);
    req_addr_i = $urandom;
    req_wdata_i = $urandom;
    req_size_i = 2'($urandom);
    req_unsigned_i = 1'($urandom);

    for (int n = 1; n <= lat; n++) begin
      inWr = !isErr && we && (n == 1);
      checkOutput("busy_ready", {31'h0, req_ready_o}, 32'h0);
      checkOutput("rsp_valid", {31'h0, rsp_valid_o}, {31'h0, n == lat});
      checkOutput("wen", {31'h0, perip_wen_o}, {31'h0, inWr});
      checkOutput("mask", {28'h0, perip_mask_o}, inWr ? {28'h0, refMask(size, addr[1:0])} : 32'h0);
      checkOutput("waddr", perip_waddr_o, addr & 32'hFFFF_FFFC);
      checkOutput("raddr", perip_raddr_o, addr & 32'hFFFF_FFFC);
      if (inWr) checkOutput("wdata", perip_wdata_o, refWdata(size, wdata));
      perip_rdata_i = (!we && !isErr && n == 2) ? capData : $urandom;
      if (n < lat) tick();
    end

    for (int s = 0; s <= stall; s++) begin
      if (s > 0) tick();
      checkOutput("rsp_hold_valid", {31'h0, rsp_valid_o}, 32'h1);
      checkOutput("rsp_rdata", rsp_rdata_o, expR);
      checkOutput("rsp_err", {31'h0, rsp_err_o}, {31'h0, isErr});
      checkOutput("rsp_hold_ready", {31'h0, req_ready_o}, 32'h0);
      checkOutput("rsp_no_wen", {31'h0, perip_wen_o}, 32'h0);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    if (!holdValid) req_valid_i = 1'b0;
    checkOutput("rsp_drop", {31'h0, rsp_valid_o}, 32'h0);
    checkOutput("ready_back", {31'h0, req_ready_o}, 32'h1);
  endtask

  initial begin
    logic [1:0]  rSize;
    logic [31:0] rAddr;

    #12;
    checkOutput("rst_ready", {31'h0, req_ready_o}, 32'h1);
    checkOutput("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    checkOutput("rst_rsp_err", {31'h0, rsp_err_o}, 32'h0);
    checkOutput("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    checkOutput("rst_wen", {31'h0, perip_wen_o}, 32'h0);
    checkOutput("rst_mask", {28'h0, perip_mask_o}, 32'h0);
    checkOutput("rst_wdata", perip_wdata_o, 32'h0);
    checkOutput("rst_waddr", perip_waddr_o, 32'h0);
    checkOutput("rst_raddr", perip_raddr_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("[TB] word load");
    applyStimulus(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 32'h1234_5678, 0, 1'b0);
    $display("[TB] signed and unsigned byte loads");
    applyStimulus(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 32'h80AA_BBCC, 0, 1'b0);
    applyStimulus(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 32'h80AA_BBCC, 0, 1'b0);
    $display("[TB] half store");
    applyStimulus(1'b1, 32'h4000_0012, 32'h0000_BEEF, 2'd1, 1'b0, 32'h0, 0, 1'b0);
    $display("[TB] misaligned word load and illegal size");
    applyStimulus(1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0, 32'h0, 0, 1'b0);
    applyStimulus(1'b1, 32'h8000_0000, 32'h1111_2222, 2'd3, 1'b0, 32'h0, 0, 1'b0);
    $display("[TB] backpressure with valid held");
    applyStimulus(1'b0, 32'h2000_0006, 32'h0, 2'd1, 1'b0, 32'hF00D_9ABC, 5, 1'b1);
    applyStimulus(1'b1, 32'h2000_0008, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0, 0, 1'b0);

    $display("[TB] reset during write");
    req_valid_i = 1'b1;
    req_we_i = 1'b1;
    req_addr_i = 32'h0000_0100;
    req_wdata_i = 32'h5555_AAAA;
    req_size_i = 2'd2;
    tick();
    req_valid_i = 1'b0;
    checkOutput("mid_wr_wen", {31'h0, perip_wen_o}, 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_wen", {31'h0, perip_wen_o}, 32'h0);
    checkOutput("arst_mask", {28'h0, perip_mask_o}, 32'h0);
    checkOutput("arst_waddr", perip_waddr_o, 32'h0);
    checkOutput("arst_wdata", perip_wdata_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("post_rst_valid", {31'h0, rsp_valid_o}, 32'h0);
      checkOutput("post_rst_ready", {31'h0, req_ready_o}, 32'h1);
    end

    $display("[TB] random transactions");
    for (int t = 0; t < 60; t++) begin
      rSize = 2'($urandom);
      rAddr = $urandom;
      if ($urandom_range(0, 3) != 0) rAddr = rAddr & ~((32'h1 << rSize) - 32'h1);
      applyStimulus(1'($urandom), rAddr, $urandom, rSize, 1'($urandom), $urandom,
                    $urandom_range(0, 3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/perip_lsu_adapter.md
PERIP_LSU_ADAPTER -- requirements
Module: perip_lsu_adapter

Interface
REQ-001 The module SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, which is the rsp_rdata_o value returned on an errored request.
REQ-002 The module SHALL use one clock and an asynchronous, active-high reset. The ports SHALL be:
- clk  in  1  — sole clock; all state updates on its rising edge.
- rst  in  1  — asynchronous, active-high reset.
- req_valid_i  in  1  — core request valid.
- req_ready_o  out  1  — adapter can accept a request.
- req_we_i  in  1  — 1 = store, 0 = load.
- req_addr_i  in  32  — byte address.
- req_wdata_i  in  32  — store data, right-aligned.
- req_size_i  in  2  — 0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned_i  in  1  — load zero-extends when 1, sign-extends when 0.
- rsp_valid_o  out  1  — response valid.
- rsp_ready_i  in  1  — core accepts the response.
- rsp_rdata_o  out  32  — load result, right-aligned and extended.
- rsp_err_o  out  1  — request was misaligned or illegal.
- perip_waddr_o  out  32  — peripheral write address.
- perip_wdata_o  out  32  — lane-replicated write data.
- perip_wen_o  out  1  — one-cycle write strobe.
- perip_mask_o  out  4  — byte-lane write enables.
- perip_raddr_o  out  32  — peripheral read address.
- perip_rdata_i  in  32  — peripheral read data; valid the cycle after perip_raddr_o is presented.

Function
REQ-003 The FSM SHALL have exactly five states: IDLE, WR, RD, CAP, RSP.
REQ-004 req_ready_o SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid_i and req_ready_o are both 1.
REQ-005 On acceptance, the adapter SHALL register addr, we, size, unsigned and wdata.
REQ-006 A request SHALL be an error when any of these holds: size = 3; size = 1 and addr[0] = 1; size = 2 and addr[1:0] != 0.
REQ-007 On an errored request, the next state SHALL be RSP with rsp_err_o = 1 and rsp_rdata_o = ERR_RDATA, and perip_wen_o SHALL never assert.
REQ-008 For a legal store, the FSM SHALL take IDLE -> WR -> RSP. perip_wen_o SHALL be 1 for exactly the one WR cycle, and rsp_rdata_o SHALL be 0.
REQ-009 For a legal load, the FSM SHALL take IDLE -> RD -> CAP -> RSP. perip_rdata_i SHALL be sampled at the end of CAP into the response register.
REQ-010 Latency from the acceptance edge to rsp_valid_o = 1 SHALL be: load 3 cycles, store 2 cycles, error 1 cycle.
REQ-011 perip_waddr_o and perip_raddr_o SHALL equal {addr_q[31:2], 2'b00} at all times.
REQ-012 perip_mask_o SHALL be 0 outside WR. In WR it SHALL be:
- byte: 4'b0001 << addr_q[1:0];
- half: 4'b0011 << {addr_q[1], 1'b0};
- word: 4'b1111.
REQ-013 perip_wdata_o SHALL be {4{wdata_q[7:0]}} for byte stores, {2{wdata_q[15:0]}} for half stores, and wdata_q for word stores.
REQ-014 For loads, the result SHALL select the byte or halfword lane indexed by addr_q[1:0] and extend it to 32 bits according to unsigned_q.
REQ-015 rsp_valid_o SHALL be 1 exactly in RSP. rsp_rdata_o and rsp_err_o SHALL be stable while rsp_valid_o = 1 and rsp_ready_i = 0.
REQ-016 RSP SHALL go to IDLE on the edge where rsp_ready_i = 1. The next request can be accepted at the earliest on the following edge; there is no same-cycle turnaround.
REQ-017 Changes on req_* inputs outside IDLE SHALL be ignored.
REQ-018 rsp_err_o SHALL be 0 for every legal request.

Reset
REQ-019 Asserting rst SHALL immediately force:
- state = IDLE;
- all request registers and the response register = 0;
- req_ready_o = 1 once rst deasserts;
- rsp_valid_o = 0, rsp_err_o = 0, rsp_rdata_o = 0;
- perip_wen_o = 0, perip_mask_o = 0, perip_wdata_o = 0;
- perip_waddr_o = 0, perip_raddr_o = 0.
REQ-020 A reset during WR SHALL drop perip_wen_o asynchronously. A reset in any state SHALL discard the in-flight request, and no response SHALL be produced for it.

Structure
REQ-021 Package perip_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W) and the state enum.
REQ-022 A combinational sub-module perip_lane_align SHALL hold the store mask, store data replication and load extraction logic. The FSM and registers SHALL remain in perip_lsu_adapter.

Verification
REQ-023 Word load: addr 0x8000_0004, perip_rdata_i = 0x1234_5678 in CAP.
- Required: perip_raddr_o = 0x8000_0004; rsp_valid_o rises 3 cycles after acceptance; rsp_rdata_o = 0x1234_5678; rsp_err_o = 0.
REQ-024 Signed byte load: addr ...03, perip_rdata_i = 0x80AA_BBCC.
- Required: rsp_rdata_o = 0xFFFF_FF80.
- Same access with req_unsigned_i = 1: rsp_rdata_o = 0x0000_0080.
REQ-025 Half store: addr ...02, wdata 0x0000_BEEF.
- Required: exactly one WR cycle with mask 4'b1100, perip_wdata_o = 0xBEEF_BEEF, perip_waddr_o = addr & ~3.
REQ-026 Misaligned word load at addr ...01.
- Required: rsp 1 cycle after acceptance; rsp_err_o = 1; rsp_rdata_o = 0xDEAD_BEEF; perip_wen_o never 1.
REQ-027 Backpressure: rsp_ready_i = 0 for 5 cycles in RSP while req_valid_i is held high.
- Required: rsp_* stable; req_ready_o = 0 throughout; next request accepted the edge after rsp_ready_i = 1 is sampled.
REQ-028 rst asserted mid-WR.
- Required: perip_wen_o = 0 immediately; after release, req_ready_o = 1 and no rsp_valid_o is produced.
